// File: rtl/watch_pkg.sv
// Shared watch encodings: modes, edit-digit positions, blank segment pattern.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    D_HH_TENS  = 2'd0,
    D_HH_UNITS = 2'd1,
    D_MM_TENS  = 2'd2,
    D_MM_UNITS = 2'd3
  } digit_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Nibble shown in scan slot s; slot 0 is the leftmost (most significant) digit.
  function automatic logic [3:0] nibble_at(input logic [15:0] word, input logic [1:0] s);
    logic [3:0] n;
    case (s)
      2'd0:    n = word[15:12];
      2'd1:    n = word[11:8];
      2'd2:    n = word[7:4];
      default: n = word[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; 10..15 blank.
// Latency: combinational.
// Backpressure: none.
module bcd7seg
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Decode table; non-decimal codes are shown blank as an error guard.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/watch_display_scan.sv
// Multiplexes time/alarm/stopwatch/split onto a 4-digit display with edit blink and alarm flash.
// Latency: outputs registered 1 cycle after slot/phase/frame_buf; new source visible within 4*SCAN_DIV+1 cycles.
// Backpressure: none; free-running scan, inputs sampled every cycle.
module watch_display_scan
  import watch_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_HALF = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_in,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] time_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic [15:0] sw_bcd,
  input  logic [15:0] split_bcd,
  input  logic        show_split,
  input  logic        alarm_ring,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic [PW-1:0] presc;
  logic [1:0]    slot;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [1:0]    prev_mode;
  logic [1:0]    prev_digit;
  logic [15:0]   frame_buf;
  logic [15:0]   src_bcd;
  logic          slot_tick;
  logic          edit_change;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          blank;
  logic          dp_next;
  mode_t         mode;

  assign mode        = mode_t'(mode_in);
  assign slot_tick   = (presc == PRESC_MAX);
  assign edit_change = (mode_in != prev_mode) || (digit_sel != prev_digit);
  assign nibble      = nibble_at(frame_buf, slot);

  // Prescaler and slot counter: one slot per SCAN_DIV cycles, 0..3 left to right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      slot  <= 2'd0;
    end else if (slot_tick) begin
      presc <= '0;
      slot  <= slot + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Blink timebase; any edit-selection change restarts it so the new digit shows at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      prev_mode  <= 2'd0;
      prev_digit <= 2'd0;
    end else begin
      prev_mode  <= mode_in;
      prev_digit <= digit_sel;
      if (edit_change) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (slot_tick) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Source selection from the watch mode.
  always_comb begin
    src_bcd = time_bcd;
    case (mode)
      MODE_NORMAL, MODE_SET_TIME: src_bcd = time_bcd;
      MODE_SET_ALARM:             src_bcd = alarm_bcd;
      MODE_STOPWATCH:             src_bcd = show_split ? split_bcd : sw_bcd;
      default:                    src_bcd = time_bcd;
    endcase
  end

  // Frame buffer loads only at the end of slot 3 so a frame is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_buf <= 16'h0;
    end else if (slot_tick && (slot == 2'd3)) begin
      frame_buf <= src_bcd;
    end
  end

  bcd7seg u_dec (
    .bcd (nibble),
    .seg (seg_dec)
  );

  // Edit-digit blink, alarm flash, and the blinking colon on slot 1.
  always_comb begin
    blank   = 1'b0;
    dp_next = 1'b1;
    if ((mode == MODE_SET_TIME || mode == MODE_SET_ALARM) && (slot == digit_sel) && phase)
      blank = 1'b1;
    if ((mode == MODE_NORMAL) && alarm_ring && phase)
      blank = 1'b1;
    if ((mode == MODE_NORMAL || mode == MODE_STOPWATCH) && (slot == 2'd1) && !phase)
      dp_next = 1'b0;
  end

  // Output registers: anode and segments update on the same edge to avoid ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b1000 >> slot);
      seg <= blank ? SEG_BLANK : seg_dec;
      dp  <= blank ? 1'b1 : dp_next;
    end
  end

endmodule

// File: tb/tb_watch_display_scan.sv
// Directed bench for watch_display_scan with SCAN_DIV=4, BLINK_HALF=8.
// Latency: edge k after reset release shows slot ((k-1)/4)%4 with phase ((k-1)/32)%2.
// Backpressure: n/a.
module tb_watch_display_scan;

  logic        clk;
  logic        rst;
  logic [1:0]  mode_in;
  logic [1:0]  digit_sel;
  logic [15:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic [15:0] sw_bcd;
  logic [15:0] split_bcd;
  logic        show_split;
  logic        alarm_ring;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_vec  = 0;
  int n_miss = 0;
  int k      = 0;

  watch_display_scan #(.SCAN_DIV(4), .BLINK_HALF(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_in    (mode_in),
    .digit_sel  (digit_sel),
    .time_bcd   (time_bcd),
    .alarm_bcd  (alarm_bcd),
    .sw_bcd     (sw_bcd),
    .split_bcd  (split_bcd),
    .show_split (show_split),
    .alarm_ring (alarm_ring),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " an"},  {12'h0, an},  16'h000F);
    check_eq({tag, " seg"}, {9'h0, seg},  16'h007F);
    check_eq({tag, " dp"},  {15'h0, dp},  16'h0001);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  // Expected outputs for the current edge k given displayed word and blink phase.
  task automatic expect_edge(input string tag, input logic [15:0] word, input logic ph);
    int s;
    logic [3:0] nib;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       blank;
    s     = ((k - 1) / 4) % 4;
    nib   = 4'((word >> (12 - 4 * s)) & 16'hF);
    e_an  = ~(4'b1000 >> s);
    blank = ((mode_in == 2'd1 || mode_in == 2'd2) && (s == int'(digit_sel)) && ph) ||
            ((mode_in == 2'd0) && alarm_ring && ph);
    e_seg = blank ? 7'h7F : seg_of(nib);
    e_dp  = ((mode_in == 2'd0 || mode_in == 2'd3) && (s == 1) && !ph && !blank) ? 1'b0 : 1'b1;
    check_eq($sformatf("%s an k=%0d", tag, k),  {12'h0, an},  {12'h0, e_an});
    check_eq($sformatf("%s seg k=%0d", tag, k), {9'h0, seg},  {9'h0, e_seg});
    check_eq($sformatf("%s dp k=%0d", tag, k),  {15'h0, dp},  {15'h0, e_dp});
  endtask

  initial begin
    rst        = 1'b1;
    mode_in    = 2'd0;
    digit_sel  = 2'd0;
    time_bcd   = 16'h1234;
    alarm_bcd  = 16'h0630;
    sw_bcd     = 16'h0102;
    split_bcd  = 16'h0959;
    show_split = 1'b0;
    alarm_ring = 1'b0;
    #2;
    check_reset_vals("por");

    // 1. Scan order and colon: first frame shows zeros, second frame 1234.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick();
      expect_edge("t1", (k <= 16) ? 16'h0000 : 16'h1234, 1'b0);
    end

    // 2. Set-time blink on mm_t; phase flips after 32 clocks.
    mode_in   = 2'd1;
    digit_sel = 2'd2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      expect_edge("t2", (k <= 16) ? 16'h0000 : 16'h1234, (((k - 1) / 32) % 2) == 1);
    end

    // 3. Edit digit moves 2->3 during phase 1: blink restarts, next wrap 32 clocks later.
    digit_sel = 2'd3;
    for (int i = 0; i < 40; i++) begin
      tick();
      expect_edge("t3", 16'h1234, (k == 41) || (k > 72));
    end

    // 4. Stopwatch with split selected mid-frame: current frame unchanged.
    mode_in   = 2'd3;
    digit_sel = 2'd0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      tick();
      if (k == 21) show_split = 1'b1;
      expect_edge("t4", (k <= 16) ? 16'h0000 : ((k <= 32) ? 16'h0102 : 16'h0959), k > 32);
    end
    show_split = 1'b0;

    // 5. Alarm flash in normal mode.
    mode_in    = 2'd0;
    alarm_ring = 1'b1;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tick();
      expect_edge("t5", (k <= 16) ? 16'h0000 : 16'h1234, k > 32);
    end
    alarm_ring = 1'b0;

    // 6. Asynchronous reset in slot 2, restart at slot 0, non-BCD nibble blanked.
    time_bcd = 16'h12C4;
    do_reset();
    for (int i = 0; i < 26; i++) tick();
    rst = 1'b1;
    #1;
    check_reset_vals("t6 async");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      expect_edge("t6", (k <= 16) ? 16'h0000 : 16'h12C4, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
